// File: rtl/ps2_scan_filter.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scan_filter
//  Description : Turns the raw PS/2 scan-code byte stream (set 2) into clean
//                key-press events. Handles the E0 (extended) and F0 (break)
//                prefixes, suppresses typematic repeats of the key that is
//                currently held, tracks the held key, and abandons a
//                dangling prefix after TIMEOUT_CYCLES idle cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_scan_filter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] rx_data,
  input  logic       rx_data_en,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_valid,
  output logic       key_held
);

  // Prefix bytes of scan-code set 2.
  localparam logic [7:0]  C_PREFIX_EXT = 8'hE0;
  localparam logic [7:0]  C_PREFIX_BRK = 8'hF0;

  // Counter value at which a pending prefix is abandoned.
  localparam logic [31:0] C_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  // Decoder position within a multi-byte scan-code sequence.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // no prefix pending
    ST_EXT     = 2'd1,  // E0 seen
    ST_BRK     = 2'd2,  // F0 seen
    ST_EXT_BRK = 2'd3   // E0 F0 seen
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  // Registered outputs.
  logic [7:0]  code_q, code_d;
  logic        ext_q, ext_d;
  logic        valid_q, valid_d;

  // Held-key register: the key most recently pressed and its valid flag.
  logic [7:0]  held_code_q, held_code_d;
  logic        held_ext_q, held_ext_d;
  logic        held_q, held_d;

  // Per-byte decode results, valid only in the cycle of rx_data_en.
  logic        make_w;      // byte completes a make code
  logic        brk_w;       // byte completes a break code
  logic        seq_ext_w;   // completed code carried the E0 prefix
  logic        timeout_w;   // pending prefix has gone stale
  logic        match_w;     // completed code equals the held key
  logic        new_make_w;  // make that is not a typematic repeat
  logic        release_w;   // break that releases the held key

  // A prefix only times out on a cycle with no incoming byte; a byte that
  // arrives on the expiry cycle is still decoded against the prefix.
  assign timeout_w = (state_q != ST_IDLE) && !rx_data_en &&
                     (cnt_q == C_TIMEOUT_LAST);

  // Next-state decode of the scan-code sequence.
  always_comb begin
    state_d   = state_q;
    make_w    = 1'b0;
    brk_w     = 1'b0;
    seq_ext_w = 1'b0;
    if (rx_data_en) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == C_PREFIX_EXT) begin
            state_d = ST_EXT;
          end else if (rx_data == C_PREFIX_BRK) begin
            state_d = ST_BRK;
          end else begin
            make_w  = 1'b1;
          end
        end
        ST_EXT: begin
          seq_ext_w = 1'b1;
          if (rx_data == C_PREFIX_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (rx_data == C_PREFIX_EXT) begin
            // Repeated E0 is harmless: keep waiting for the code byte.
            state_d = ST_EXT;
          end else begin
            make_w  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          // Whatever follows F0 is the released key, even a prefix value.
          brk_w   = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          brk_w     = 1'b1;
          seq_ext_w = 1'b1;
          state_d   = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (timeout_w) begin
      state_d = ST_IDLE;
    end
  end

  // Idle-gap counter: runs only while a prefix is pending.
  always_comb begin
    cnt_d = cnt_q;
    if (rx_data_en || (state_q == ST_IDLE) || timeout_w) begin
      cnt_d = 32'd0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Classify a completed code against the held key.
  always_comb begin
    match_w    = held_q && (held_code_q == rx_data) && (held_ext_q == seq_ext_w);
    new_make_w = make_w && !match_w;
    release_w  = brk_w && match_w;
  end

  // Next values of the event outputs and the held-key register.
  always_comb begin
    valid_d     = new_make_w;
    code_d      = code_q;
    ext_d       = ext_q;
    held_code_d = held_code_q;
    held_ext_d  = held_ext_q;
    held_d      = held_q;
    if (new_make_w) begin
      code_d      = rx_data;
      ext_d       = seq_ext_w;
      held_code_d = rx_data;
      held_ext_d  = seq_ext_w;
      held_d      = 1'b1;
    end else if (release_w) begin
      // Only the flag drops; key_code keeps showing the last press.
      held_d = 1'b0;
    end
  end

  // Decoder state and idle-gap counter registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output and held-key registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      code_q      <= 8'h00;
      ext_q       <= 1'b0;
      valid_q     <= 1'b0;
      held_code_q <= 8'h00;
      held_ext_q  <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      code_q      <= code_d;
      ext_q       <= ext_d;
      valid_q     <= valid_d;
      held_code_q <= held_code_d;
      held_ext_q  <= held_ext_d;
      held_q      <= held_d;
    end
  end

  assign key_code     = code_q;
  assign key_extended = ext_q;
  assign key_valid    = valid_q;
  assign key_held     = held_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_scan_filter
//  Description : Self-checking bench for ps2_scan_filter. Stimulus pushes the
//                expected key presses into a scoreboard; a monitor pops and
//                compares on every key_valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_scan_filter;

  localparam int TO = 16;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_data_en = 1'b0;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_valid;
  logic       key_held;

  ps2_scan_filter #(.TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .rx_data      (rx_data),
    .rx_data_en   (rx_data_en),
    .key_code     (key_code),
    .key_extended (key_extended),
    .key_valid    (key_valid),
    .key_held     (key_held)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Rising-edge count; a byte driven now is sampled at edge cyc+1.
  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  // Reference model: prefix flags plus the currently held key.
  logic       m_pext, m_pbrk;
  logic       m_held, m_hext, m_lext;
  logic [7:0] m_hcode, m_lcode;
  int         m_last;

  task automatic model_reset();
    m_pext = 0; m_pbrk = 0; m_held = 0; m_hext = 0; m_lext = 0;
    m_hcode = 8'h00; m_lcode = 8'h00; m_last = 0;
    sb.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input int sc);
    exp_t e;
    // A prefix older than TO cycles has been abandoned.
    if ((m_pext || m_pbrk) && (sc - m_last > TO)) begin
      m_pext = 0;
      m_pbrk = 0;
    end
    m_last = sc;
    if (m_pbrk) begin
      if (m_held && m_hcode == b && m_hext == m_pext) m_held = 0;
      m_pext = 0;
      m_pbrk = 0;
    end else if (b == 8'hE0) begin
      m_pext = 1;
    end else if (b == 8'hF0) begin
      m_pbrk = 1;
    end else begin
      if (!(m_held && m_hcode == b && m_hext == m_pext)) begin
        e.code = b; e.ext = m_pext; e.cyc = sc;
        sb.push_back(e);
        m_held = 1; m_hcode = b; m_hext = m_pext;
        m_lcode = b; m_lext = m_pext;
      end
      m_pext = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the oldest expected press, one cycle late.
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (resetn && key_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: key_code=%h ext=%b at cycle %0d, none expected",
                 key_code, key_extended, cyc);
      end else begin
        e = sb.pop_front();
        if (key_code !== e.code || key_extended !== e.ext || cyc != e.cyc) begin
          errors++;
          $display("FAIL pulse: got code=%h ext=%b cycle=%0d expected code=%h ext=%b cycle=%0d",
                   key_code, key_extended, cyc, e.code, e.ext, e.cyc);
        end
      end
    end
  end

  task automatic check_state();
    check("missing_pulse", 32'(sb.size()), 32'd0);
    if (sb.size() != 0) sb.delete();
    check("key_held", 32'(key_held), 32'(m_held));
    check("key_code", 32'(key_code), 32'(m_lcode));
    check("key_extended", 32'(key_extended), 32'(m_lext));
  endtask

  // Called at a falling edge; idle=0 leaves the strobe high for the next byte.
  task automatic send_byte(input logic [7:0] b, input int idle);
    model_byte(b, cyc + 1);
    rx_data    = b;
    rx_data_en = 1'b1;
    @(negedge CLOCK_50);
    rx_data_en = 1'b0;
    if (idle > 0) begin
      repeat (idle) @(negedge CLOCK_50);
      check_state();
    end
  endtask

  // Asynchronous reset asserted mid-cycle, released on a falling edge.
  task automatic do_reset(input int n);
    #2;
    resetn     = 1'b0;
    rx_data_en = 1'b0;
    model_reset();
    #1;
    check("reset_async", {22'd0, key_code, key_extended, key_valid}, 32'd0);
    check("reset_held", 32'(key_held), 32'd0);
    repeat (n) @(negedge CLOCK_50);
    check("reset_hold", {21'd0, key_code, key_extended, key_valid, key_held}, 32'd0);
    resetn = 1'b1;
  endtask

  logic [7:0] pool [6];

  initial begin
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h33;
    pool[3] = 8'h1B; pool[4] = 8'h75; pool[5] = 8'h23;
    model_reset();
    @(negedge CLOCK_50);
    do_reset(3);
    @(negedge CLOCK_50);

    // Single make.
    send_byte(8'h33, 3);

    // Typematic repeats, release, re-press.
    do_reset(2);
    send_byte(8'h33, 10); send_byte(8'h33, 10); send_byte(8'h33, 10);
    send_byte(8'hF0, 2);  send_byte(8'h33, 3);
    send_byte(8'h33, 3);

    // Extended make; plain break ignored; extended break releases.
    do_reset(2);
    send_byte(8'hE0, 2); send_byte(8'h75, 3);
    send_byte(8'hF0, 2); send_byte(8'h75, 3);
    send_byte(8'hE0, 2); send_byte(8'hF0, 2); send_byte(8'h75, 3);

    // Non-matching break.
    do_reset(2);
    send_byte(8'h33, 3); send_byte(8'hF0, 2); send_byte(8'h1B, 3);

    // Abandoned break prefix.
    do_reset(2);
    send_byte(8'hF0, 20); send_byte(8'h23, 3);

    // Timeout boundary: gap 16 keeps the prefix, gap 17 drops it.
    send_byte(8'hF0, 15); send_byte(8'h23, 3);
    send_byte(8'h23, 3);
    send_byte(8'hF0, 16); send_byte(8'h23, 3);
    send_byte(8'hE0, 15); send_byte(8'h75, 3);
    send_byte(8'hE0, 16); send_byte(8'h75, 3);

    // Reset while a prefix is pending.
    do_reset(2);
    send_byte(8'hE0, 2);
    do_reset(3);
    @(negedge CLOCK_50);
    send_byte(8'h1B, 3);

    // Back-to-back bytes, two makes on consecutive cycles.
    send_byte(8'hE0, 0); send_byte(8'h75, 0); send_byte(8'h33, 0);
    send_byte(8'hF0, 0); send_byte(8'h33, 3);

    // Reset landing on a key_valid pulse.
    model_byte(8'h4B, cyc + 1);
    rx_data = 8'h4B; rx_data_en = 1'b1;
    @(posedge CLOCK_50);
    #1;
    check("pulse_before_reset", 32'(key_valid), 32'd1);
    rx_data_en = 1'b0;
    #1;
    resetn = 1'b0;
    model_reset();
    #1;
    check("pulse_killed", {23'd0, key_code, key_valid}, 32'd0);
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);

    // Random byte stream.
    for (int i = 0; i < 300; i++) begin
      send_byte(pool[$urandom_range(0, 5)], $urandom_range(0, 20));
    end
    repeat (4) @(negedge CLOCK_50);
    check_state();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ps2_scan_filter.md
PS2_SCAN_FILTER -- requirements
Module: ps2_scan_filter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, the maximum number of cycles allowed between a prefix byte (E0/F0) and its following byte (20 ms at 50 MHz).
REQ-002 SHALL have port CLOCK_50  input  1  the system clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  the reset: asynchronous, active-low.
REQ-004 SHALL have port rx_data  input  8  the received PS/2 byte from the PS/2 controller.
REQ-005 SHALL have port rx_data_en  input  1  a single-cycle strobe; rx_data is valid when it is 1.
REQ-006 SHALL have port key_code  output  8  the make code of the last newly pressed key, held between events.
REQ-007 SHALL have port key_extended  output  1  set to 1 when key_code was prefixed by E0.
REQ-008 SHALL have port key_valid  output  1  a one-cycle pulse marking a new key press.
REQ-009 SHALL have port key_held  output  1  set to 1 while the last pressed key has not been released.

Function
REQ-010 SHALL implement decoder states IDLE, EXT (after E0), BRK (after F0) and EXT_BRK (after E0 F0).
REQ-011 In IDLE, the block SHALL act on each byte as follows:
  - E0 -> EXT
  - F0 -> BRK
  - any other byte -> completed make, ext=0, stay in IDLE
REQ-012 In EXT, the block SHALL act on each byte as follows:
  - F0 -> EXT_BRK
  - E0 -> stay in EXT
  - any other byte -> completed make, ext=1, then IDLE
REQ-013 In BRK, any byte SHALL be a completed break with ext=0, then IDLE.
REQ-014 In EXT_BRK, any byte SHALL be a completed break with ext=1, then IDLE.
REQ-015 The block SHALL keep an internal held register {held_ext, held_code}; key_held is its valid flag.
REQ-016 On a completed make whose {ext, byte} equals the held register while key_held=1 (typematic repeat), the block SHALL produce no pulse and change no output.
REQ-017 On any other completed make, on the next rising edge the block SHALL:
  - set key_valid=1 for exactly one cycle
  - load key_code=byte and key_extended=ext
  - load the held register and set key_held=1
REQ-018 Latency SHALL be 1 cycle from the rx_data_en of the completing byte to key_valid.
REQ-019 On a completed break matching the held register, the block SHALL clear key_held on the next edge; a non-matching break SHALL be ignored.
REQ-020 key_code and key_extended SHALL hold their values until the next non-repeat make.
REQ-021 A 32-bit-max timeout counter SHALL behave as follows:
  - clears on every rx_data_en and while in IDLE
  - increments in the other states
  - when it reaches TIMEOUT_CYCLES-1, the state returns to IDLE, the pending prefix is discarded, and the held register is unchanged
REQ-022 If rx_data_en and the timeout coincide, the byte SHALL be processed in the current state and the timeout ignored.
REQ-023 rx_data_en on consecutive cycles SHALL each be processed; no byte is dropped.
REQ-024 key_valid SHALL never be high on two consecutive cycles unless two distinct makes complete on consecutive cycles.

Reset
REQ-025 While resetn=0, the block SHALL hold the state at IDLE, the counter at 0, and key_code=8'h00, key_extended=0, key_valid=0, key_held=0, held register=0.
REQ-026 Assertion of resetn mid-sequence (in any non-IDLE state, or during a key_valid pulse) SHALL take effect immediately without waiting for a clock edge.
REQ-027 After resetn deasserts, the first byte SHALL be decoded from IDLE.

Verification (TIMEOUT_CYCLES=16 on the bench)
REQ-028 Bytes 33 -> key_valid high 1 cycle, key_code=33, key_extended=0, key_held=1.
REQ-029 Bytes 33,33,33 (spaced 10 cycles) -> exactly one key_valid pulse; then F0,33 -> key_held=0; then 33 -> second pulse, key_code=33.
REQ-030 Bytes E0,75 -> pulse, key_code=75, key_extended=1; then F0,75 -> key_held stays 1; then E0,F0,75 -> key_held=0.
REQ-031 Bytes 33 then F0,1B -> key_held stays 1, key_code stays 33, no pulse.
REQ-032 Byte F0, 20 idle cycles, then 23 -> 23 decoded as a make: pulse, key_code=23, key_extended=0.
REQ-033 Byte E0, then resetn low for 3 cycles and released, then 1B -> all outputs 0 during reset; after release a pulse with key_code=1B, key_extended=0.
